// File: rtl/m3_speed_ramp_ctrl.sv
// Motor-3 run controller: turns operator pulses into step enable, direction, ramped period and power.
// All outputs registered; reversal always passes through a full ramp-down to PERIOD_MAX.
module m3_speed_ramp_ctrl #(
  parameter logic [21:0] PERIOD_MAX = 22'd2000000,
  parameter logic [21:0] PERIOD_MIN = 22'd20000,
  parameter logic [21:0] SPEED_STEP = 22'd20000,
  parameter logic [21:0] RAMP_DELTA = 22'd1000,
  parameter logic [15:0] RAMP_TICK  = 16'd50000,
  parameter logic [3:0]  POWER_INIT = 4'd8
) (
  input  logic        clkI,
  input  logic        nRstI,
  input  logic        m3startI,
  input  logic        m3forceStopI,
  input  logic        m3invRotateI,
  input  logic        m3speedINCi,
  input  logic        m3speedDECi,
  input  logic        m3powerINCi,
  input  logic        m3powerDECi,
  output logic        stepEnO,
  output logic        dirO,
  output logic [31:0] dstRoundLenO,
  output logic [3:0]  powerLvlO,
  output logic [2:0]  stateO
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RAMP_UP = 3'd1;
  localparam logic [2:0] RUN     = 3'd2;
  localparam logic [2:0] RAMP_DN = 3'd3;
  localparam logic [2:0] HALT    = 3'd4;

  logic [2:0]  state, stateD;
  logic        stepEn, stepEnD, dir, dirD, revPending, revPendingD;
  logic [21:0] period, periodD, target, targetD, goal, rampNext;
  logic [22:0] tgtUp;
  logic [3:0]  power, powerD, powerLvl;
  logic [15:0] tickCnt, tickCntD;
  logic        tick, isRamp;

  always_comb begin
    targetD = target;
    tgtUp   = {1'b0, target} + {1'b0, SPEED_STEP};
    if (m3speedINCi && !m3speedDECi) begin
      if ({1'b0, target} < ({1'b0, PERIOD_MIN} + {1'b0, SPEED_STEP})) targetD = PERIOD_MIN;
      else targetD = target - SPEED_STEP;
    end else if (m3speedDECi && !m3speedINCi) begin
      if (tgtUp > {1'b0, PERIOD_MAX}) targetD = PERIOD_MAX;
      else targetD = tgtUp[21:0];
    end
  end

  always_comb begin
    powerD = power;
    if (m3powerINCi && !m3powerDECi && power != 4'd15) powerD = power + 4'd1;
    else if (m3powerDECi && !m3powerINCi && power != 4'd0) powerD = power - 4'd1;
  end

  // One ramp step toward the goal, clamped so it never overshoots.
  always_comb begin
    goal = (state == RAMP_DN) ? PERIOD_MAX : target;
    rampNext = period;
    if (period > goal) rampNext = ((period - goal) > RAMP_DELTA) ? period - RAMP_DELTA : goal;
    else if (period < goal) rampNext = ((goal - period) > RAMP_DELTA) ? period + RAMP_DELTA : goal;
  end

  assign isRamp = (state == RAMP_UP) || (state == RUN) || (state == RAMP_DN);
  assign tick   = (tickCnt == RAMP_TICK - 16'd1);

  always_comb begin
    stateD      = state;
    stepEnD     = stepEn;
    dirD        = dir;
    revPendingD = revPending;
    periodD     = (isRamp && tick) ? rampNext : period;
    if (m3forceStopI) begin
      stateD      = HALT;
      stepEnD     = 1'b0;
      periodD     = PERIOD_MAX;
      revPendingD = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          stepEnD = 1'b0;
          periodD = PERIOD_MAX;
          if (m3startI) begin
            stateD  = RAMP_UP;
            dirD    = m3invRotateI;
            stepEnD = 1'b1;
          end
        end
        RAMP_UP, RUN: begin
          if (!m3startI) stateD = RAMP_DN;
          else if (m3invRotateI != dir) begin
            stateD      = RAMP_DN;
            revPendingD = 1'b1;
          end else if (state == RAMP_UP && periodD == target) stateD = RUN;
        end
        RAMP_DN: begin
          if (periodD == PERIOD_MAX) begin
            if (revPending) begin
              dirD        = ~dir;
              revPendingD = 1'b0;
            end
            if (revPending && m3startI) stateD = RAMP_UP;
            else begin
              stateD  = IDLE;
              stepEnD = 1'b0;
            end
          end
        end
        HALT: begin
          stepEnD     = 1'b0;
          periodD     = PERIOD_MAX;
          revPendingD = 1'b0;
          if (!m3startI) stateD = IDLE;
        end
        default: begin
          stateD  = IDLE;
          stepEnD = 1'b0;
          periodD = PERIOD_MAX;
        end
      endcase
    end
    if (stateD != state || !isRamp || tick) tickCntD = 16'd0;
    else tickCntD = tickCnt + 16'd1;
  end

  always_ff @(posedge clkI) begin
    if (!nRstI) begin
      state      <= IDLE;
      stepEn     <= 1'b0;
      dir        <= 1'b0;
      period     <= PERIOD_MAX;
      target     <= PERIOD_MAX;
      power      <= POWER_INIT;
      tickCnt    <= 16'd0;
      revPending <= 1'b0;
      powerLvl   <= 4'd0;
    end else begin
      state      <= stateD;
      stepEn     <= stepEnD;
      dir        <= dirD;
      period     <= periodD;
      target     <= targetD;
      power      <= powerD;
      tickCnt    <= tickCntD;
      revPending <= revPendingD;
      powerLvl   <= stepEnD ? powerD : 4'd0;
    end
  end

  assign stepEnO      = stepEn;
  assign dirO         = dir;
  assign dstRoundLenO = {10'd0, period};
  assign powerLvlO    = powerLvl;
  assign stateO       = state;
endmodule

// File: doc/m3_speed_ramp_ctrl.md
Name: m3_speed_ramp_ctrl

Overview:
- Motor-3 run controller that sequences the step calculator.
- Turns operator pulses (start, stop, speed, power, direction) into:
  - a step-enable level,
  - a direction bit,
  - a ramped step-period value, which drives the step calculator's dstRoundLenI,
  - a power level.
- Ramps the period between a slow start/stop period and a user target. Reverses direction only through a full ramp-down.

Parameters:
PERIOD_MAX, 22'd2000000, slowest step period in clocks; start/stop period and target ceiling
PERIOD_MIN, 22'd20000, fastest allowed target period
SPEED_STEP, 22'd20000, target change per speed INC/DEC pulse
RAMP_DELTA, 22'd1000, maximum period change per ramp tick
RAMP_TICK, 16'd50000, clocks between ramp ticks (>=2)
POWER_INIT, 4'd8, power level after reset

Ports:
clkI  input  1  clock
nRstI  input  1  reset, synchronous, active-low
m3startI  input  1  level; 1 = run requested
m3forceStopI  input  1  level; 1 = immediate stop
m3invRotateI  input  1  level; requested direction
m3speedINCi  input  1  1-clk pulse; faster (target period - SPEED_STEP)
m3speedDECi  input  1  1-clk pulse; slower (target period + SPEED_STEP)
m3powerINCi  input  1  1-clk pulse; power level +1
m3powerDECi  input  1  1-clk pulse; power level -1
stepEnO  output  1  run enable to step calculator
dirO  output  1  active rotation direction
dstRoundLenO  output  32  current step period, zero-extended from 22 bits
powerLvlO  output  4  effective power level
stateO  output  3  FSM state code

Behaviour:
- Reset: only on clkI rising edge with nRstI==0.
  - Reset values: state=IDLE, stepEnO=0, dirO=0, period=PERIOD_MAX, target=PERIOD_MAX, power=POWER_INIT, tick counter=0, revPending=0.
- States: IDLE=0, RAMP_UP=1, RUN=2, RAMP_DN=3, HALT=4.
- Priority 1: m3forceStopI=1 in any state -> HALT next clk.
  - HALT: stepEnO=0, period=PERIOD_MAX, revPending=0.
  - HALT->IDLE when force=0 and start=0.
- IDLE: stepEnO=0, period=PERIOD_MAX.
  - start=1 -> RAMP_UP; same edge: dirO<=m3invRotateI, stepEnO<=1.
- RAMP_UP / RUN:
  - Period moves toward target by one ramp step per tick.
  - RAMP_UP->RUN on the clk where period==target.
  - In RUN, target changes are tracked with the same ramp; state stays RUN.
  - start=0 -> RAMP_DN.
  - m3invRotateI!=dirO -> RAMP_DN with revPending<=1.
- RAMP_DN: period moves toward PERIOD_MAX. On reaching it:
  - If revPending: dirO<=~dirO, revPending<=0, then RAMP_UP if start=1, else IDLE with stepEnO=0.
  - Else: IDLE with stepEnO=0.
  - start re-asserted during RAMP_DN does not abort the ramp-down.
- Ramp step:
  - Going down: period > goal -> period = (period-goal > RAMP_DELTA) ? period-RAMP_DELTA : goal.
  - Going up: symmetric. Never overshoots the goal.
- Tick counter:
  - Counts 0..RAMP_TICK-1 in RAMP_UP/RUN/RAMP_DN.
  - Tick at count RAMP_TICK-1, then wraps to 0.
  - Cleared to 0 on every state change and in IDLE/HALT.
  - First ramp update comes RAMP_TICK clks after entering a ramp state.
- Target:
  - INC: target = max(target-SPEED_STEP, PERIOD_MIN).
  - DEC: target = min(target+SPEED_STEP, PERIOD_MAX).
  - Saturating, 23-bit intermediate, accepted in every state.
  - INC and DEC on the same clk: ignored.
  - Retained across stops.
- Power:
  - Saturating 0..15; INC and DEC on the same clk: ignored.
  - powerLvlO = stepEnO ? power : 0.
- All outputs are registered; one clk latency from input to output.

Test Plan:
Sim params: PERIOD_MAX=100, PERIOD_MIN=20, SPEED_STEP=10, RAMP_DELTA=7, RAMP_TICK=4.
- Reset, then 9 speedINC pulses -> target saturates at 20 (not 10); outputs stay stepEnO=0, dstRoundLenO=100, powerLvlO=0.
- target=70, start=1 -> stepEnO=1 next clk; period 93,86,79,72,70 at 4-clk intervals; RUN on the clk period hits 70.
- In RUN at 70, drop start -> RAMP_DN; period 77,84,91,98,100; IDLE and stepEnO=0 on reaching 100.
- In RUN with dirO=0, set invRotate=1 -> ramp to 100, dirO=1, ramp back to 70 with stepEnO held 1 throughout.
- forceStop mid RAMP_UP at period 86 -> next clk HALT, stepEnO=0, period=100; IDLE only after both force and start are 0.
- Reset mid-RUN and simultaneous INC+DEC pulses:
  - Reset mid-RUN -> all reset values after one clk.
  - Simultaneous INC+DEC pulses -> target and power unchanged.
  - 10 powerINC pulses from 8 -> power saturates at 15.
